spi_master_scheduler: RTL and testbench

Round-robin scheduler that shares one `spi_module_master` byte engine between `N_REQ` requesters.
- Each granted requester gets a multi-byte burst under its own chip-select, held low across all bytes; the master's own per-byte `spi_cs` is not used for slave selection.
- The block sequences the master with `spi_en`, feeds `spi_mosi_data` one byte per transfer, and returns each `spi_miso_data` byte to the requester on `payload_done`.

---
 rtl/spi_master_scheduler.sv | 155 +++++++++++++++
 tb/tb_spi_master_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_scheduler.sv
// Round-robin scheduler lending one SPI byte engine to N_REQ requesters; each grant
// runs a multi-byte burst under its own chip-select with setup/hold gaps around it.
module spi_master_scheduler #(
    parameter int N_REQ      = 4,
    parameter int LEN_W      = 8,
    parameter int GAP_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*LEN_W-1:0] req_len,
    input  logic [N_REQ*8-1:0]     tx_data,
    output logic [N_REQ-1:0]       tx_pop,
    output logic [7:0]             rx_data,
    output logic [N_REQ-1:0]       rx_valid,
    output logic [N_REQ-1:0]       done,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       cs_n,
    output logic                   m_spi_en,
    output logic [7:0]             m_mosi_data,
    input  logic [7:0]             m_miso_data,
    input  logic                   m_payload_done
);
    // state | meaning
    // IDLE  | arbitrate req from rr_ptr; zero-length grants finish here
    // SETUP | cs_n low, waiting GAP_CYCLES before the first byte
    // LOAD  | pop next TX byte into the master, raise m_spi_en
    // XFER  | byte in flight, waiting for m_payload_done
    // HOLD  | last byte done, waiting before cs_n release and done
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, SETUP, LOAD, XFER, HOLD} state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] rr_ptr, g_idx, sel_idx, scan_idx;
    logic [N_REQ-1:0] sel_oh;
    logic             sel_found;
    logic [LEN_W-1:0] rem, sel_len;
    logic [7:0]       g_tx;
    logic [CNT_W-1:0] gap_cnt;
    logic             gap_zero;

    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_REQ - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign gap_zero = (gap_cnt == '0);

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = rr_ptr;
        scan_idx  = rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!sel_found && req[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
            scan_idx = inc_ptr(scan_idx);
        end
    end

    always_comb begin
        sel_oh  = '0;
        sel_len = '0;
        g_tx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel_idx == PTR_W'(i)) begin
                sel_oh[i] = 1'b1;
                sel_len   = req_len[i*LEN_W +: LEN_W];
            end
            if (g_idx == PTR_W'(i))
                g_tx = tx_data[i*8 +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tx_pop    = '0;
        case (state)
            IDLE:    if (sel_found && sel_len != '0) state_nxt = SETUP;
            SETUP:   if (gap_zero) state_nxt = LOAD;
            LOAD: begin
                tx_pop    = grant;
                state_nxt = XFER;
            end
            XFER:    if (m_payload_done) state_nxt = (rem != '0) ? LOAD : HOLD;
            HOLD:    if (gap_zero) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr      <= '0;
            g_idx       <= '0;
            rem         <= '0;
            gap_cnt     <= '0;
            grant       <= '0;
            cs_n        <= '1;
            done        <= '0;
            rx_valid    <= '0;
            rx_data     <= '0;
            m_spi_en    <= 1'b0;
            m_mosi_data <= '0;
        end else begin
            done     <= '0;
            rx_valid <= '0;
            case (state)
                IDLE: if (sel_found) begin
                    g_idx <= sel_idx;
                    rem   <= sel_len;
                    if (sel_len == '0) begin
                        done   <= sel_oh;
                        rr_ptr <= inc_ptr(sel_idx);
                    end else begin
                        grant   <= sel_oh;
                        cs_n    <= ~sel_oh;
                        gap_cnt <= CNT_W'(GAP_CYCLES - 1);
                    end
                end
                SETUP: if (!gap_zero) gap_cnt <= gap_cnt - CNT_W'(1);
                LOAD: begin
                    m_mosi_data <= g_tx;
                    rem         <= rem - LEN_W'(1);
                    m_spi_en    <= 1'b1;
                end
                XFER: if (m_payload_done) begin
                    m_spi_en <= 1'b0;
                    rx_data  <= m_miso_data;
                    rx_valid <= grant;
                    // Hold counts one extra edge so cs_n rises GAP_CYCLES+1 after the last byte.
                    if (rem == '0) gap_cnt <= CNT_W'(GAP_CYCLES);
                end
                HOLD: if (gap_zero) begin
                    cs_n   <= '1;
                    done   <= grant;
                    grant  <= '0;
                    rr_ptr <= inc_ptr(g_idx);
                end else begin
                    gap_cnt <= gap_cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_scheduler.sv
// Directed bench for spi_master_scheduler with an echoing byte-engine model and
// per-requester TX byte feeders.
module tb_spi_master_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_len;
    logic [31:0] tx_data;
    logic [3:0]  tx_pop, rx_valid, done, grant, cs_n;
    logic [7:0]  rx_data, m_mosi_data, m_miso_data;
    logic        m_spi_en, m_payload_done;

    spi_master_scheduler #(.N_REQ(4), .LEN_W(8), .GAP_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len), .tx_data(tx_data),
        .tx_pop(tx_pop), .rx_data(rx_data), .rx_valid(rx_valid), .done(done),
        .grant(grant), .cs_n(cs_n), .m_spi_en(m_spi_en), .m_mosi_data(m_mosi_data),
        .m_miso_data(m_miso_data), .m_payload_done(m_payload_done)
    );

    initial forever #5 clk = ~clk;

    logic [7:0] tx_bytes [4][8];
    int         tx_idx [4];
    int         pop_cnt [4];
    int         done_cnt [4];
    int         cyc, busy_cnt, done_total, en_rise_cnt;
    int         grant_q[$], rx_req_q[$], en_gap_q[$];
    logic [7:0] rx_dat_q[$];
    int         cs_fall_cyc, cs_rise_cyc, pop_first_cyc, en_first_cyc, en_fall_cyc;
    int         last_pd_cyc, min_cs_high, overlap_cnt, cs_inv_err;
    logic [3:0] grant_prev, cs_prev, pop_prev;
    logic       en_prev;
    int         checks, passes;

    function automatic int oh2idx(input logic [3:0] x);
        for (int i = 0; i < 4; i++)
            if (x == 4'(1 << i)) return i;
        return -1;
    endfunction

    // Master model, TX feeders and event logging, all on the falling edge.
    initial begin
        cyc = 0; busy_cnt = 0; done_total = 0; en_rise_cnt = 0;
        m_payload_done = 1'b0; m_miso_data = '0; tx_data = '0;
        cs_fall_cyc = -1; cs_rise_cyc = -1; pop_first_cyc = -1; en_first_cyc = -1;
        en_fall_cyc = -1; last_pd_cyc = -1; min_cs_high = 1000;
        overlap_cnt = 0; cs_inv_err = 0;
        grant_prev = '0; cs_prev = '1; pop_prev = '0; en_prev = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tx_idx[i] = 0; pop_cnt[i] = 0; done_cnt[i] = 0;
            for (int k = 0; k < 8; k++) tx_bytes[i][k] = '0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            if (m_spi_en && !m_payload_done) begin
                busy_cnt++;
                if (busy_cnt == 3) begin
                    m_payload_done = 1'b1;
                    m_miso_data    = m_mosi_data;
                    busy_cnt       = 0;
                    last_pd_cyc    = cyc;
                end
            end else begin
                m_payload_done = 1'b0;
                busy_cnt       = 0;
            end
            for (int i = 0; i < 4; i++) begin
                if (pop_prev[i]) tx_idx[i]++;
                pop_cnt[i]  += int'(tx_pop[i]);
                done_cnt[i] += int'(done[i]);
                tx_data[i*8 +: 8] = tx_bytes[i][tx_idx[i] % 8];
            end
            pop_prev = tx_pop;
            if (done != '0) done_total++;
            if (rx_valid != '0) begin
                rx_req_q.push_back(oh2idx(rx_valid));
                rx_dat_q.push_back(rx_data);
            end
            if (grant != '0 && grant_prev == '0) grant_q.push_back(oh2idx(grant));
            if (cs_n != 4'hF && cs_prev == 4'hF) begin
                cs_fall_cyc = cyc;
                if (cs_rise_cyc >= 0 && cyc - cs_rise_cyc < min_cs_high)
                    min_cs_high = cyc - cs_rise_cyc;
            end
            if (cs_n == 4'hF && cs_prev != 4'hF) cs_rise_cyc = cyc;
            if ($countones(~cs_n) > 1) overlap_cnt++;
            if (cs_n !== ~grant) cs_inv_err++;
            if (tx_pop != '0 && pop_first_cyc < 0) pop_first_cyc = cyc;
            if (m_spi_en && !en_prev) begin
                en_rise_cnt++;
                if (en_first_cyc < 0) en_first_cyc = cyc;
                if (en_fall_cyc >= 0) en_gap_q.push_back(cyc - en_fall_cyc);
            end
            if (!m_spi_en && en_prev) en_fall_cyc = cyc;
            grant_prev = grant;
            cs_prev    = cs_n;
            en_prev    = m_spi_en;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic arm();
        pop_first_cyc = -1; en_first_cyc = -1; en_fall_cyc = -1;
        en_gap_q.delete(); rx_req_q.delete(); rx_dat_q.delete();
    endtask

    task automatic wait_grants(input int target, input string tag);
        for (int i = 0; i < 2000 && grant_q.size() < target; i++) step();
        chk(tag, grant_q.size(), target);
    endtask

    task automatic wait_done(input int target, input string tag);
        for (int i = 0; i < 2000 && done_total < target; i++) step();
        chk(tag, done_total, target);
    endtask

    int base_g, base_d, base_pop, base_dc, base_en;

    initial begin
        checks = 0; passes = 0;
        rst = 1'b1; req = '0; req_len = '0;
        step(3);
        chk("rst_cs_n", cs_n, 4'hF);
        chk("rst_grant", grant, 4'h0);
        chk("rst_spi_en", m_spi_en, 1'b0);
        chk("rst_mosi", m_mosi_data, 8'h00);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 4'h0);
        chk("rst_done", done, 4'h0);
        chk("rst_tx_pop", tx_pop, 4'h0);
        rst = 1'b0;
        step(2);

        // Contention: requesters 0 and 2 together, pointer starts at 0.
        tx_bytes[0][0] = 8'h11; tx_bytes[0][1] = 8'h22;
        tx_bytes[2][0] = 8'h33; tx_bytes[2][1] = 8'h44;
        tx_idx[0] = 0; tx_idx[2] = 0;
        req_len = {8'd0, 8'd2, 8'd0, 8'd2};
        arm();
        base_g = grant_q.size(); base_d = done_total;
        req = 4'b0101;
        wait_grants(base_g + 2, "cont_grants_timeout");
        req = '0;
        wait_done(base_d + 2, "cont_done_timeout");
        chk("cont_first", grant_q[base_g], 0);
        chk("cont_second", grant_q[base_g + 1], 2);
        chk("cont_pop0", pop_cnt[0], 2);
        chk("cont_pop2", pop_cnt[2], 2);
        chk("cont_rx_count", rx_req_q.size(), 4);
        chk("cont_rx0_data", {rx_dat_q[0], rx_dat_q[1]}, 16'h1122);
        chk("cont_rx2_data", {rx_dat_q[2], rx_dat_q[3]}, 16'h3344);
        chk("cont_rx_owner", {rx_req_q[0][1:0], rx_req_q[1][1:0], rx_req_q[2][1:0], rx_req_q[3][1:0]}, 8'b00_00_10_10);
        chk("cont_overlap", overlap_cnt, 0);

        // Zero length with req[1] and req[3]: pointer 3 selects requester 3.
        req_len = '0;
        base_d = done_total; base_en = en_rise_cnt; base_dc = done_cnt[1];
        req = 4'b1010;
        step();
        req = '0;
        chk("zero_done_pulse", done, 4'b1000);
        chk("zero_cs_n", cs_n, 4'hF);
        chk("zero_grant", grant, 4'h0);
        step();
        chk("zero_done_clear", done, 4'h0);
        step(4);
        chk("zero_done_total", done_total, base_d + 1);
        chk("zero_no_done1", done_cnt[1], base_dc);
        chk("zero_no_spi_en", en_rise_cnt, base_en);

        // Fairness: all four held, one byte each.
        req_len = {8'd1, 8'd1, 8'd1, 8'd1};
        for (int i = 0; i < 4; i++) begin
            tx_idx[i] = 0;
            tx_bytes[i][0] = 8'(8'h80 + i);
            tx_bytes[i][1] = 8'(8'h90 + i);
        end
        arm();
        base_g = grant_q.size(); base_d = done_total; min_cs_high = 1000;
        req = 4'hF;
        wait_grants(base_g + 8, "fair_grants_timeout");
        req = '0;
        wait_done(base_d + 8, "fair_done_timeout");
        for (int k = 0; k < 8; k++) chk("fair_order", grant_q[base_g + k], k % 4);
        chk("fair_min_cs_high", min_cs_high, 1);
        chk("fair_rx_count", rx_req_q.size(), 8);
        chk("fair_overlap", overlap_cnt, 0);

        // Single 3-byte burst on requester 1, including gap timing.
        tx_bytes[1][0] = 8'hA5; tx_bytes[1][1] = 8'h3C; tx_bytes[1][2] = 8'hF0;
        tx_idx[1] = 0;
        req_len = {8'd0, 8'd0, 8'd3, 8'd0};
        arm();
        base_g = grant_q.size(); base_d = done_total;
        base_pop = pop_cnt[1]; base_dc = done_cnt[1];
        req = 4'b0010;
        wait_grants(base_g + 1, "single_grant_timeout");
        req = '0;
        chk("single_cs_n", cs_n, 4'b1101);
        wait_done(base_d + 1, "single_done_timeout");
        chk("single_grant", grant_q[base_g], 1);
        chk("single_pops", pop_cnt[1] - base_pop, 3);
        chk("single_done1", done_cnt[1] - base_dc, 1);
        chk("single_rx_count", rx_req_q.size(), 3);
        chk("single_rx_data", {rx_dat_q[0], rx_dat_q[1], rx_dat_q[2]}, 24'hA53CF0);
        chk("single_rx_owner", {rx_req_q[0][1:0], rx_req_q[1][1:0], rx_req_q[2][1:0]}, 6'b01_01_01);
        chk("single_en_gaps", en_gap_q.size(), 2);
        // m_spi_en drops at the payload_done edge and returns at the LOAD edge.
        for (int k = 0; k < en_gap_q.size(); k++) chk("single_en_low", en_gap_q[k], 1);
        chk("gap_cs_to_load", pop_first_cyc - cs_fall_cyc, 4);
        chk("gap_cs_to_en", en_first_cyc - cs_fall_cyc, 5);
        // payload_done is logged half a cycle before the edge that samples it.
        chk("gap_pd_to_cs_rise", cs_rise_cyc - last_pd_cyc, 6);
        chk("single_cs_inv", cs_inv_err, 0);

        // Reset during byte 2 of a 4-byte burst on requester 2.
        for (int k = 0; k < 4; k++) tx_bytes[2][k] = 8'(8'h61 + k);
        tx_bytes[0][0] = 8'h77;
        tx_idx[2] = 0; tx_idx[0] = 0;
        req_len = {8'd0, 8'd4, 8'd0, 8'd1};
        arm();
        base_g = grant_q.size(); base_dc = done_cnt[2];
        req = 4'b0100;
        wait_grants(base_g + 1, "rst_grant_timeout");
        for (int i = 0; i < 300 && !(rx_req_q.size() == 1 && m_spi_en); i++) step();
        chk("rst_reach_byte2", (rx_req_q.size() == 1 && m_spi_en), 1'b1);
        req = 4'b1001;
        step();
        chk("rst_grant_held", grant, 4'b0100);
        base_d = done_total;
        rst = 1'b1;
        #1;
        chk("rst_mid_spi_en", m_spi_en, 1'b0);
        chk("rst_mid_cs_n", cs_n, 4'hF);
        chk("rst_mid_grant", grant, 4'h0);
        step(3);
        chk("rst_mid_no_done", done_total, base_d);
        rst = 1'b0;
        wait_grants(base_g + 2, "rst_regrant_timeout");
        req = '0;
        chk("rst_regrant_owner", grant_q[base_g + 1], 0);
        wait_done(base_d + 1, "rst_redone_timeout");
        chk("rst_no_done2", done_cnt[2], base_dc);
        chk("rst_rx_last", rx_dat_q[rx_dat_q.size() - 1], 8'h77);
        chk("final_overlap", overlap_cnt, 0);
        chk("final_cs_inv", cs_inv_err, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
